// File: rtl/canny_pkg.sv
// canny_pkg: shared image geometry defaults, pixel width, streamer FSM states and helpers
package canny_pkg;

    localparam int DEF_IMG_WIDTH  = 512;
    localparam int DEF_IMG_HEIGHT = 512;
    localparam int PIXEL_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_GAP,
        ST_DRAIN
    } stream_state_e;

    // Frame/line markers that travel alongside each issued read
    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pixel_tag_t;

    // Counter width that stays legal for degenerate ranges of 0 or 1
    function automatic int clog2_min1(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_streamer_if.sv
// pixel_streamer_if: frame-memory read port plus outgoing pixel stream and control
interface pixel_streamer_if
    import canny_pkg::*;
#(
    parameter int ITEM_SIZE = PIXEL_W,
    parameter int ADDR_W    = 18
);

    logic                 start;
    logic                 hold;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [ITEM_SIZE-1:0] mem_rdata;
    logic [ITEM_SIZE-1:0] pixel_out;
    logic                 pixel_out_valid;
    logic                 sof;
    logic                 eol;
    logic                 eof;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, hold, mem_rdata,
        output mem_rd_en, mem_addr, pixel_out, pixel_out_valid, sof, eol, eof, busy, done
    );

    modport slave (
        output start, hold, mem_rdata,
        input  mem_rd_en, mem_addr, pixel_out, pixel_out_valid, sof, eol, eof, busy, done
    );

endinterface

// File: rtl/raster_counter.sv
// raster_counter: raster-order x/y position and linear address with end-of-line/frame flags
module raster_counter
    import canny_pkg::*;
#(
    parameter int WIDTH  = DEF_IMG_WIDTH,
    parameter int HEIGHT = DEF_IMG_HEIGHT,
    parameter int ADDR_W = 18,
    localparam int XW    = clog2_min1(WIDTH),
    localparam int YW    = clog2_min1(HEIGHT)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              en_i,
    output logic [XW-1:0]     x_o,
    output logic [YW-1:0]     y_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              eol_o,
    output logic              eof_o
);

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign eol_o  = x_q == XW'(WIDTH - 1);
    assign eof_o  = eol_o && y_q == YW'(HEIGHT - 1);
    assign x_o    = x_q;
    assign y_o    = y_q;
    assign addr_o = addr_q;

    // Step one pixel per enable; the address runs linearly and wraps with the frame
    always_comb begin
        x_d    = en_i ? (eol_o ? '0 : x_q + 1'b1) : x_q;
        y_d    = en_i && eol_o ? (eof_o ? '0 : y_q + 1'b1) : y_q;
        addr_d = en_i ? (eof_o ? '0 : addr_q + 1'b1) : addr_q;
    end

    // Position registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/pixel_streamer.sv
// pixel_streamer: reads one frame from synchronous memory and emits it as a tagged pixel stream
module pixel_streamer
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int ITEM_SIZE  = PIXEL_W,
    parameter int ADDR_W     = 18,
    parameter int LINE_GAP   = 0,
    localparam int XW        = clog2_min1(IMG_WIDTH),
    localparam int YW        = clog2_min1(IMG_HEIGHT),
    localparam int GW        = clog2_min1(LINE_GAP)
) (
    input logic               clk,
    input logic               rstN,
    pixel_streamer_if.master  bus
);

    stream_state_e        state_q, state_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 rd_en;
    logic                 line_end;
    logic                 frame_end;
    logic [XW-1:0]        x;
    logic [YW-1:0]        y;
    pixel_tag_t           tag_rd, tag1_q, tag_q;
    logic                 vld1_q, vld_q;
    logic [ITEM_SIZE-1:0] pix_q;

    raster_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk    (clk),
        .rstN   (rstN),
        .en_i   (rd_en),
        .x_o    (x),
        .y_o    (y),
        .addr_o (bus.mem_addr),
        .eol_o  (line_end),
        .eof_o  (frame_end)
    );

    assign tag_rd              = '{sof: x == '0 && y == '0, eol: line_end, eof: frame_end};
    assign bus.mem_rd_en       = rd_en;
    assign bus.pixel_out       = pix_q;
    assign bus.pixel_out_valid = vld_q;
    assign bus.sof             = tag_q.sof;
    assign bus.eol             = tag_q.eol;
    assign bus.eof             = tag_q.eof;
    assign bus.done            = tag_q.eof;
    assign bus.busy            = state_q != ST_IDLE;

    // Sequencing: issue reads, pause for line gaps, then wait for the final pixel to leave
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_READ;
            ST_READ: if (!bus.hold) begin
                rd_en = 1'b1;
                if (frame_end) state_d = ST_DRAIN;
                else if (line_end && LINE_GAP > 0) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: if (!bus.hold) begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(LINE_GAP - 1)) begin
                    state_d = ST_READ;
                    gap_d   = '0;
                end
            end
            ST_DRAIN: if (tag_q.eof) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and gap counter
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Tags ride one stage alongside the memory latency, then register with the read data
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            vld1_q <= 1'b0;
            tag1_q <= '0;
            vld_q  <= 1'b0;
            tag_q  <= '0;
            pix_q  <= '0;
        end else begin
            vld1_q <= rd_en;
            tag1_q <= rd_en ? tag_rd : '0;
            vld_q  <= vld1_q;
            tag_q  <= tag1_q;
            if (vld1_q) pix_q <= bus.mem_rdata;
        end
    end

endmodule
